// File: rtl/mips_mem_pkg.sv
// Shared encodings for the unified-memory arbiter.
package mips_mem_pkg;

    typedef enum logic {
        ARB_BOOT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of consecutive CPU grants taken while the loader waits.
module arb_burst_counter #(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(MAX_CPU_BURST + 1);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX_CPU_BURST));

    // Clear wins over increment; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between the datapath and the program loader:
// loader-only boot phase, then per-cycle CPU-priority arbitration with
// bounded loader starvation.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_run,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_boot_done,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    owner_t     owner;
    logic       cpu_req;
    logic       at_max;

    assign cpu_req   = cpu_rd | cpu_wr;
    assign cpu_run   = (state == ARB_RUN);
    assign ld_gnt    = (owner == OWN_LD);
    assign cpu_stall = cpu_req & (owner != OWN_CPU);
    assign cpu_rdata = mem_rdata;

    // State register; reset returns to BOOT even mid-access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Boot completes once; ld_boot_done is ignored in RUN.
    always_comb begin
        state_nxt = state;
        if (state == ARB_BOOT && ld_boot_done) begin
            state_nxt = ARB_RUN;
        end
    end

    // Grant decision: loader only in BOOT, CPU priority with burst limit in RUN.
    always_comb begin
        owner = OWN_NONE;
        if (state == ARB_BOOT) begin
            if (ld_req) owner = OWN_LD;
        end else if (cpu_req && ld_req) begin
            owner = at_max ? OWN_LD : OWN_CPU;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (ld_req) begin
            owner = OWN_LD;
        end
    end

    // Memory port mux; idle port is driven to all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
            end
            OWN_LD: begin
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
                mem_rd    = ~ld_we;
                mem_wr    = ld_we;
            end
            default: ;
        endcase
    end

    arb_burst_counter #(
        .MAX_CPU_BURST(MAX_CPU_BURST)
    ) u_burst (
        .clk    (clk),
        .reset  (reset),
        .inc    ((owner == OWN_CPU) && ld_req),
        .clr    ((owner == OWN_LD) || !ld_req),
        .at_max (at_max)
    );

    // Loader read data is registered and presented for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_rvalid <= (owner == OWN_LD) && !ld_we;
            if ((owner == OWN_LD) && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed steps then random traffic against a
// behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr, cpu_stall, cpu_run;
    logic        ld_req, ld_we, ld_boot_done, ld_gnt, ld_rvalid;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_CPU_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_run(cpu_run),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_boot_done(ld_boot_done), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    // Memory: asynchronous read, write on the rising edge.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;

    // Reference model state
    logic [31:0] ref_mem [256];
    bit          m_run;
    int          m_wait;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          m_lwin;

    int   checks = 0;
    int   errors = 0;
    logic last_ld_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [7:0] ca,
                       input logic [31:0] cw, input bit lr, input bit lwe, input logic [7:0] la,
                       input logic [31:0] lw, input bit bd);
        bit creq, cwin, lwin, erd, ewr;
        logic [31:0] ea, ed;
        reset = rst; cpu_rd = rd; cpu_wr = wr; cpu_addr = {24'b0, ca}; cpu_wdata = cw;
        ld_req = lr; ld_we = lwe; ld_addr = {24'b0, la}; ld_wdata = lw; ld_boot_done = bd;
        #2;
        creq = rd | wr;
        if (!m_run) begin
            lwin = lr; cwin = 1'b0;
        end else if (creq && lr) begin
            lwin = (m_wait >= MAXB); cwin = !lwin;
        end else begin
            cwin = creq; lwin = lr;
        end
        ea = '0; ed = '0; erd = 1'b0; ewr = 1'b0;
        if (cwin) begin
            ea = {24'b0, ca}; ed = cw; erd = rd; ewr = wr;
        end else if (lwin) begin
            ea = {24'b0, la}; ed = lw; erd = !lwe; ewr = lwe;
        end
        chk("ld_gnt",    32'(ld_gnt),    32'(lwin));
        chk("cpu_stall", 32'(cpu_stall), 32'(creq && !cwin));
        chk("mem_rd",    32'(mem_rd),    32'(erd));
        chk("mem_wr",    32'(mem_wr),    32'(ewr));
        chk("mem_addr",  mem_addr,       ea);
        chk("mem_wdata", mem_wdata,      ed);
        chk("cpu_run",   32'(cpu_run),   32'(m_run));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_rvalid));
        chk("ld_rdata",  ld_rdata,       m_rdata);
        if (cwin && rd) chk("cpu_rdata", cpu_rdata, ref_mem[ca]);
        last_ld_gnt = ld_gnt;
        m_lwin = lwin;
        @(posedge clk);
        #1;
        m_rvalid = lwin && !lwe;
        if (m_rvalid) m_rdata = ref_mem[la];
        if (ewr) ref_mem[ea[7:0]] = ed;
        if (lwin || !lr) m_wait = 0;
        else if (cwin) m_wait++;
        if (!m_run && bd) m_run = 1'b1;
        if (rst) begin
            m_run = 1'b0; m_wait = 0; m_rvalid = 1'b0; m_rdata = '0;
        end
    endtask

    task automatic idle(input bit bd);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, bd);
    endtask

    initial begin
        logic [11:0] pat;
        bit          lp, lpwe, rst, rd, wr;
        logic [7:0]  lpa;
        logic [31:0] lpw;

        for (int i = 0; i < 256; i++) begin
            mem[i] = '0; ref_mem[i] = '0;
        end
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_boot_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_run = 1'b0; m_wait = 0; m_rvalid = 1'b0; m_rdata = '0; m_lwin = 1'b0;

        // Reset state, all outputs idle
        idle(1'b0);
        // BOOT: loader write with a competing CPU read
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h00, 32'h8C010004, 1'b0);
        chk("boot_write_mem0", mem[0], 32'h8C010004);
        // BOOT: loader read, data one cycle later
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        chk("boot_read_rvalid", 32'(ld_rvalid), 32'h1);
        chk("boot_read_rdata", ld_rdata, 32'h8C010004);
        // Boot done, CPU runs the next cycle
        idle(1'b1);
        chk("cpu_run_rise", 32'(cpu_run), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        // Contention for 12 cycles
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0);
            pat[i] = last_ld_gnt;
        end
        chk("burst_pattern", 32'(pat), 32'h210);
        // Second boot-done pulse has no effect
        idle(1'b1);
        chk("cpu_run_hold", 32'(cpu_run), 32'h1);
        // CPU read+write together
        cyc(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        chk("rdwr_mem10", mem[16], 32'hDEADBEEF);
        // Reset during a loader read
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        chk("rst_cpu_run", 32'(cpu_run), 32'h0);
        chk("rst_rvalid", 32'(ld_rvalid), 32'h0);
        idle(1'b0);

        // Random traffic; loader holds its request until granted
        lp = 1'b0; lpwe = 1'b0; lpa = '0; lpw = '0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!lp && $urandom_range(0, 1) == 1) begin
                lp = 1'b1; lpwe = 1'($urandom_range(0, 1));
                lpa = 8'($urandom_range(0, 255)); lpw = $urandom;
            end
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            cyc(rst, rd, wr, 8'($urandom_range(0, 255)), $urandom, lp, lpwe, lpa, lpw,
                ($urandom_range(0, 15) == 0));
            if (m_lwin || rst) lp = 1'b0;
        end
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

The arbiter shares the single unified instruction/data memory between the multi-cycle datapath and an external program loader. After reset it runs a boot phase in which the loader owns the memory exclusively while the CPU is held in reset. Once the loader signals completion, it arbitrates access per cycle: the CPU has priority, with bounded starvation for the loader. It sits between the datapath's memory-address mux / B register and the memory, and also drives the datapath's reset input.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MAX_CPU_BURST, 4, max consecutive CPU grants while the loader is waiting (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_W  datapath memory address
- cpu_wdata  in  DATA_W  datapath store data
- cpu_rd  in  1  datapath read request
- cpu_wr  in  1  datapath write request
- cpu_rdata  out  DATA_W  memory read data to the IR/MDR
- cpu_stall  out  1  the CPU requested but was not granted this cycle
- cpu_run  out  1  0 = datapath held in reset (drive datapath reset with ~cpu_run)
- ld_req  in  1  loader access request
- ld_we  in  1  loader access is a write
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_boot_done  in  1  single-cycle pulse: program image loaded
- ld_gnt  out  1  loader granted this cycle
- ld_rdata  out  DATA_W  registered loader read data
- ld_rvalid  out  1  ld_rdata valid (one-cycle pulse)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data

## Operation
- State machine has two states: BOOT and RUN. Reset forces BOOT from any state, mid-access included.
- BOOT:
  - The loader gets the memory whenever ld_req is high.
  - CPU requests are never granted.
  - On ld_boot_done, go to RUN. A grant in the same cycle still completes.
- RUN:
  - ld_boot_done is ignored.
  - Only one side requesting: that side is granted.
  - Both requesting: the CPU wins, unless burst_cnt == MAX_CPU_BURST; then the loader wins.
- burst_cnt behaviour:
  - Increments on a CPU grant while ld_req is high.
  - Clears on any loader grant, or in any cycle where ld_req is low.
  - Never exceeds MAX_CPU_BURST.
  - Width is clog2(MAX_CPU_BURST+1).
- Memory port driving:
  - Granted owner drives the port. CPU: mem_rd=cpu_rd, mem_wr=cpu_wr. Loader: mem_rd=~ld_we, mem_wr=ld_we.
  - No grant: addr, wdata, rd and wr are all 0.
  - CPU asserting cpu_rd and cpu_wr together: both pass through.
- cpu_stall = (cpu_rd|cpu_wr) & ~cpu_gnt. It is combinational and covers BOOT as well.
- cpu_rdata = mem_rdata, passed through unconditionally. The datapath captures it only when not stalled.
- cpu_stall gates the datapath's PCWr, IRwrite and RegWrite. The control FSM must not advance while cpu_stall is high.
- The loader holds ld_req, ld_we, ld_addr and ld_wdata stable until ld_gnt. Each ld_gnt completes exactly one access.

## Timing
- Memory reads are asynchronous: mem_rdata is valid in the same cycle as mem_rd. Writes commit on the rising edge with mem_wr high.
- Grant decision, mem_* outputs, cpu_stall and ld_gnt are combinational from the requests and registered state. Granted access latency is 0 cycles.
- ld_rdata and ld_rvalid are registered. A loader read granted in cycle N gives ld_rvalid=1 and ld_rdata=mem_rdata in cycle N+1.
- cpu_run rises in the cycle after the ld_boot_done pulse. CPU requests can be granted from that cycle on.
- Worst-case loader wait in RUN is MAX_CPU_BURST cycles. Worst-case CPU wait is 1 cycle per loader grant.
- Reset values:
  - Registers: state=BOOT, cpu_run=0, burst_cnt=0, ld_rvalid=0, ld_rdata=0.
  - Combinational outputs with no requests pending: all 0.

## Structure
- Shared package mips_mem_pkg holds:
  - state encodings ARB_BOOT=1'b0 and ARB_RUN=1'b1
  - owner encodings OWN_NONE, OWN_CPU, OWN_LD
- One sub-module is natural: arb_burst_counter, a saturating counter with inc/clr and an at_max flag, parameterised by MAX_CPU_BURST.
- Grant logic and output muxing stay inline.

## Test plan
- Reset then loader writes 0x8C010004 to addr 0 -> ld_gnt=1 the same cycle, mem_wr=1; cpu_run=0; a CPU read at 0 in BOOT gives cpu_stall=1.
- Loader read of addr 0 in BOOT -> ld_rvalid=1 and ld_rdata=0x8C010004 exactly one cycle later.
- ld_boot_done pulse at cycle T -> cpu_run=1 at T+1; a CPU read of addr 0 at T+1 gives cpu_stall=0 and cpu_rdata=0x8C010004.
- RUN, cpu_rd and ld_req both held high for 12 cycles, MAX_CPU_BURST=4 -> grant pattern CPU×4, LD×1, repeated; cpu_stall=1 exactly in the LD cycles.
- RUN, a second ld_boot_done pulse -> no state change; assert reset mid loader read -> next cycle cpu_run=0, ld_rvalid=0, burst_cnt=0, state BOOT.
- CPU asserts cpu_rd and cpu_wr together at addr 0x10 with data 0xDEADBEEF -> mem_rd=mem_wr=1, memory holds 0xDEADBEEF after the edge.
